// File: rtl/urv_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// urv_mem_arb_pkg
//   Shared types and constants for the mem_if arbiter slice.
//   - mem_req_t  : request payload carried on every mem_if request channel
//   - mem_resp_t : response payload; 'last' closes a transaction
//   - MEM_ARB_RESP_DEPTH : default response-buffer / in-flight depth
//   - MST_IFETCH / MST_LSU : master ids stored in the route FIFO
// ----------------------------------------------------------------------------
package urv_mem_arb_pkg;

    localparam int unsigned MEM_ARB_RESP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        last;
    } mem_resp_t;

    localparam logic MST_IFETCH = 1'b0;
    localparam logic MST_LSU    = 1'b1;

endpackage

// File: rtl/urv_mem_arb_fifo.sv
// ----------------------------------------------------------------------------
// urv_sync_fifo
//   Single-clock FIFO with registered storage and no read bypass.
//   Pointers carry one extra wrap bit so full and empty are distinct.
//   Push while full and pop while empty are ignored.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   push, wdata    write request and data
//   pop            remove head entry
//   rdata          head entry (valid while !empty)
//   full, empty    occupancy flags
// ----------------------------------------------------------------------------
module urv_sync_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/urv_mem_arb.sv
// ----------------------------------------------------------------------------
// urv_mem_arb
//   Two-master to one-slave mem_if arbiter in front of the SRAM bridge.
//   m0 = instruction fetch, m1 = load/store.
//   Round-robin arbitration, grant locked while the slave stalls, credit-
//   limited issue so every response has a buffer slot; responses are
//   returned in issue order through a registered buffer (1 cycle latency).
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   mX_req_valid/ready/req     master X request channel
//   mX_resp_valid/ready/resp   master X response channel
//   s_req_valid/ready/req      slave request channel (combinational mux)
//   s_resp_valid/ready/resp    slave response channel (ready tied high)
// ----------------------------------------------------------------------------
module urv_mem_arb
    import urv_mem_arb_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = MEM_ARB_RESP_DEPTH
) (
    input  logic      clk,
    input  logic      rstn,

    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,

    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,

    output logic      s_req_valid,
    input  logic      s_req_ready,
    output mem_req_t  s_req,
    input  logic      s_resp_valid,
    output logic      s_resp_ready,
    input  mem_resp_t s_resp
);

    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned RESP_W = 1 + $bits(mem_resp_t);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             rr;
    logic             lock;
    logic             lock_id;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic              has_credit;
    logic              grant_id;
    logic              sel_valid;
    logic              req_hs;

    logic              rt_head_id;
    logic              rt_full;
    logic              rt_empty;
    logic              rt_pop;

    logic [RESP_W-1:0] rb_wdata;
    logic [RESP_W-1:0] rb_head;
    logic              rb_full;
    logic              rb_empty;
    logic              head_id;
    mem_resp_t         head_resp;
    logic              resp_pop;
    logic              cnt_inc;
    logic              cnt_dec;

    // ------------------------------------------------------------------
    // Arbitration: a held grant wins over the round-robin choice so the
    // payload seen by a stalled slave cannot change.
    // ------------------------------------------------------------------
    always_comb begin
        grant_id = MST_IFETCH;
        if (lock) begin
            grant_id = lock_id;
        end else if (m0_req_valid && m1_req_valid) begin
            grant_id = rr;
        end else if (m1_req_valid) begin
            grant_id = MST_LSU;
        end
    end

    assign has_credit   = (cnt < CNT_MAX);
    assign sel_valid    = (grant_id == MST_LSU) ? m1_req_valid : m0_req_valid;
    assign s_req        = (grant_id == MST_LSU) ? m1_req : m0_req;
    assign s_req_valid  = sel_valid && has_credit;
    assign req_hs       = s_req_valid && s_req_ready;

    assign m0_req_ready = (grant_id == MST_IFETCH) && s_req_ready && has_credit;
    assign m1_req_ready = (grant_id == MST_LSU)    && s_req_ready && has_credit;

    assign s_resp_ready = 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr      <= MST_IFETCH;
            lock    <= 1'b0;
            lock_id <= MST_IFETCH;
        end else begin
            if (req_hs) begin
                rr   <= ~grant_id;
                lock <= 1'b0;
            end else if (s_req_valid) begin
                lock    <= 1'b1;
                lock_id <= grant_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Route FIFO: which master owns each outstanding slave transaction.
    // ------------------------------------------------------------------
    assign rt_pop = s_resp_valid && s_resp.last;

    urv_sync_fifo #(
        .WIDTH (1),
        .DEPTH (RESP_DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (req_hs),
        .wdata (grant_id),
        .pop   (rt_pop),
        .rdata (rt_head_id),
        .full  (rt_full),
        .empty (rt_empty)
    );

    // ------------------------------------------------------------------
    // Response buffer: {owner id, response}, drained in arrival order.
    // ------------------------------------------------------------------
    assign rb_wdata = {rt_head_id, s_resp};

    urv_sync_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_buf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (s_resp_valid),
        .wdata (rb_wdata),
        .pop   (resp_pop),
        .rdata (rb_head),
        .full  (rb_full),
        .empty (rb_empty)
    );

    assign head_id       = rb_head[RESP_W-1];
    assign head_resp     = rb_head[RESP_W-2:0];

    assign m0_resp_valid = !rb_empty && (head_id == MST_IFETCH);
    assign m1_resp_valid = !rb_empty && (head_id == MST_LSU);
    assign m0_resp       = head_resp;
    assign m1_resp       = head_resp;

    assign resp_pop = (m0_resp_valid && m0_resp_ready) ||
                      (m1_resp_valid && m1_resp_ready);

    // ------------------------------------------------------------------
    // Credits: a slot is held from issue until the master consumes the
    // final beat, which bounds both FIFOs to RESP_DEPTH entries.
    // ------------------------------------------------------------------
    assign cnt_inc = req_hs;
    assign cnt_dec = resp_pop && head_resp.last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol / invariant checks
    // ------------------------------------------------------------------
    a_resp_has_route: assert property (@(posedge clk) disable iff (!rstn)
        s_resp_valid |-> !rt_empty);

    a_route_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        req_hs |-> !rt_full);

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        s_resp_valid |-> !rb_full);

endmodule

// File: tb/tb_urv_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_urv_mem_arb
//   Directed scenarios followed by a randomized phase. A transaction-level
//   model (outstanding count, last-granted master, held grant, queue of
//   expected responses with their earliest visible cycle) predicts every
//   observable output each cycle. The slave is modelled with a fixed
//   one-cycle response latency.
// ----------------------------------------------------------------------------
module tb_urv_mem_arb;
    import urv_mem_arb_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic      clk = 1'b0;
    logic      rstn;
    logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t  m0_req, m1_req, s_req;
    mem_resp_t m0_resp, m1_resp, s_resp;
    logic      s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;

    always #5 clk = ~clk;

    urv_mem_arb #(.RESP_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_req        (m0_req),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m0_resp       (m0_resp),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_req        (m1_req),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .m1_resp       (m1_resp),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req         (s_req),
        .s_resp_valid  (s_resp_valid),
        .s_resp_ready  (s_resp_ready),
        .s_resp        (s_resp)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        int          avail;
    } exp_t;

    exp_t        gq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          outstanding = 0;
    int          prefer = 0;
    bit          hold_act = 0;
    int          hold_id = 0;
    int          rem[2];
    logic [31:0] addr[2];
    int          dut_hs_id;
    int          hs_cnt;
    int          start_pref;
    int          gl[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        m0_req_valid = (rem[0] > 0);
        m0_req       = '0;
        m0_req.addr  = addr[0];
        m0_req.be    = 4'hF;
        m1_req_valid = (rem[1] > 0);
        m1_req       = '0;
        m1_req.addr  = addr[1];
        m1_req.be    = 4'hF;
    endtask

    // One clock cycle: predict and compare, then advance the model and slave.
    task automatic cyc();
        bit          v[2];
        bit          cred;
        bit          sv;
        bit          vis;
        bit          rsp_hs;
        bit          hs;
        int          g;
        int          hid;
        logic [31:0] d = '0;
        string       tag;
        #1;
        v[0] = m0_req_valid;
        v[1] = m1_req_valid;
        cred = (outstanding < DEPTH);
        if (hold_act)          g = hold_id;
        else if (v[0] && v[1]) g = prefer;
        else if (v[1])         g = 1;
        else                   g = 0;
        sv = v[g] && cred;
        if (v[0]) check("m0_req_ready", 32'(m0_req_ready), 32'(g == 0 && s_req_ready && cred));
        if (v[1]) check("m1_req_ready", 32'(m1_req_ready), 32'(g == 1 && s_req_ready && cred));
        if (v[0] || v[1]) check("s_req_valid", 32'(s_req_valid), 32'(sv));
        if (sv) check("s_req_addr", s_req.addr, addr[g]);

        vis = (gq.size() > 0) && (gq[0].avail <= cyc_n);
        hid = vis ? gq[0].id : -1;
        check("m0_resp_valid", 32'(m0_resp_valid), 32'(hid == 0));
        check("m1_resp_valid", 32'(m1_resp_valid), 32'(hid == 1));
        rsp_hs = vis && ((hid == 0) ? m0_resp_ready : m1_resp_ready);
        if (rsp_hs) begin
            tag = (hid == 0) ? "m0_resp_data" : "m1_resp_data";
            check(tag, (hid == 0) ? m0_resp.rdata : m1_resp.rdata, gq[0].data);
            void'(gq.pop_front());
            outstanding--;
        end

        dut_hs_id = (m0_req_valid && m0_req_ready) ? 0 :
                    (m1_req_valid && m1_req_ready) ? 1 : -1;
        hs = sv && s_req_ready;
        if (hs) begin
            d = mem_data(addr[g]);
            gq.push_back('{g, d, cyc_n + 2});
            outstanding++;
            prefer   = 1 - g;
            hold_act = 1'b0;
        end else if (sv) begin
            hold_act = 1'b1;
            hold_id  = g;
        end

        @(posedge clk);
        #1;
        cyc_n++;
        s_resp_valid = hs;
        s_resp       = '0;
        s_resp.rdata = d;
        s_resp.last  = 1'b1;
        if (hs) begin
            rem[g]--;
            addr[g] = addr[g] + 32'd4;
        end
    endtask

    task automatic drain();
        rem[0] = 0;
        rem[1] = 0;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        s_req_ready   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (gq.size() == 0 && outstanding == 0) break;
            apply();
            cyc();
        end
        check("drain_empty", 32'(gq.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        rem[0] = 0; rem[1] = 0;
        addr[0] = '0; addr[1] = '0;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        s_req_ready   = 1'b1;
        s_resp_valid  = 1'b0;
        s_resp        = '0;
        apply();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
        check("rst_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
        check("rst_s_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_s_resp_ready", 32'(s_resp_ready), 32'd1);
        rstn = 1'b1;

        // Single m0 read of 0x100
        rem[0] = 1; addr[0] = 32'h100;
        apply(); cyc();
        check("t1_grant_m0", 32'(dut_hs_id), 32'd0);
        apply(); cyc();
        apply();
        #1;
        check("t1_resp_visible", 32'(m0_resp_valid), 32'd1);
        check("t1_resp_data", m0_resp.rdata, 32'hDEAD_BEEF);
        cyc();
        drain();

        // Both masters competing: grants alternate
        start_pref = prefer;
        rem[0] = 4; rem[1] = 4;
        addr[0] = 32'h1000; addr[1] = 32'h2000;
        gl.delete();
        for (int i = 0; i < 30 && gl.size() < 4; i++) begin
            apply(); cyc();
            if (dut_hs_id >= 0) gl.push_back(dut_hs_id);
        end
        check("t2_grant_count", 32'(gl.size()), 32'd4);
        for (int k = 0; k < gl.size(); k++)
            check("t2_grant_order", 32'(gl[k]), 32'((start_pref + k) % 2));
        drain();

        // Credit exhaustion with m1 response backpressure
        m1_resp_ready = 1'b0;
        rem[1] = 3; addr[1] = 32'h3000;
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            apply(); cyc();
            if (dut_hs_id >= 0) hs_cnt++;
        end
        check("t3_issued", 32'(hs_cnt), 32'd2);
        apply();
        #1;
        check("t3_m1_blocked", 32'(m1_req_ready), 32'd0);
        m1_resp_ready = 1'b1;
        for (int i = 0; i < 15 && rem[1] > 0; i++) begin
            apply(); cyc();
        end
        check("t3_third_issued", 32'(rem[1]), 32'd0);
        drain();

        // Grant lock while the slave stalls
        rem[0] = 1; addr[0] = 32'h300;
        for (int i = 0; i < 5 && rem[0] > 0; i++) begin
            apply(); cyc();
        end
        drain();
        s_req_ready = 1'b0;
        rem[0] = 1; addr[0] = 32'h400;
        apply(); cyc();
        rem[1] = 1; addr[1] = 32'h500;
        apply(); cyc();
        apply(); cyc();
        apply();
        #1;
        check("t4_hold_addr", s_req.addr, 32'h400);
        s_req_ready = 1'b1;
        cyc();
        check("t4_m0_hs", 32'(dut_hs_id), 32'd0);
        apply(); cyc();
        check("t4_m1_next", 32'(dut_hs_id), 32'd1);
        drain();

        // Response and request handshakes in the same cycle at one credit
        rem[0] = 1; addr[0] = 32'h600;
        apply(); cyc();
        apply(); cyc();
        rem[1] = 1; addr[1] = 32'h700;
        apply(); cyc();
        check("t5_same_cycle_hs", 32'(dut_hs_id), 32'd1);
        m0_resp_ready = 1'b0;
        m1_resp_ready = 1'b0;
        rem[0] = 2; addr[0] = 32'h800;
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            apply(); cyc();
            if (dut_hs_id >= 0) hs_cnt++;
        end
        check("t5_one_more_issue", 32'(hs_cnt), 32'd1);
        drain();

        // Reset with two buffered responses
        m1_resp_ready = 1'b0;
        rem[1] = 2; addr[1] = 32'h900;
        for (int i = 0; i < 6; i++) begin
            apply(); cyc();
        end
        rem[1] = 0;
        apply();
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
        check("t6_rst_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
        check("t6_rst_s_req_valid", 32'(s_req_valid), 32'd0);
        gq.delete();
        outstanding  = 0;
        prefer       = 0;
        hold_act     = 1'b0;
        s_resp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m1_resp_ready = 1'b1;
        rem[1] = 1; addr[1] = 32'hA00;
        apply(); cyc();
        check("t6_m1_reissue", 32'(dut_hs_id), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply(); cyc();
        end
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    rem[i]  = 1;
                    addr[i] = $urandom & 32'h0000_FFFC;
                end
            end
            m0_resp_ready = ($urandom_range(0, 3) != 0);
            m1_resp_ready = ($urandom_range(0, 3) != 0);
            s_req_ready   = ($urandom_range(0, 3) != 0);
            apply(); cyc();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
